cutelock_key_sequencer: RTL and testbench
=========================================

// Module: cutelock_key_sequencer
// PURPOSE
//   Feeds the time-varying unlock key schedule to a Cute-Lock encrypted FSM core.
//   - Holds NUM_KEYS keys of KEY_W bits, loaded over a config port.
//   - Resets the core, then drives the key for the active epoch so the core's internal window counter is always matched.
//   - Sits between the secure key store / config bus and the locked core's keyinput bus.
// PARAMETERS
//   KEY_W      18  width of one key (core keyinput bus width)
//   NUM_KEYS   6   keys (epochs) per schedule period
//   EPOCH_LEN  6   core clock cycles per epoch
//   RST_CYC    2   cycles core_rst is held high on start/abort
// PORTS
//   clk         in   1                   clock (rising edge)
//   rst         in   1                   reset, asynchronous, active-high
//   cfg_we      in   1                   write key cfg_key into slot cfg_idx
//   cfg_idx     in   $clog2(NUM_KEYS)    key slot index
//   cfg_key     in   KEY_W               key data
//   cfg_commit  in   1                   seal table (all slots must be written)
//   start       in   1                   pulse: reset core, begin keyed run
//   abort       in   1                   pulse: stop run, re-reset core
//   core_rst    out  1                   reset to locked core
//   key_out     out  KEY_W               key to core keyinput bus
//   epoch_idx   out  $clog2(NUM_KEYS)    epoch currently driven
//   busy        out  1                   in RSTC or RUN
//   ready       out  1                   table committed, idle
//   err         out  1                   sticky protocol error; cleared only by rst
// BEHAVIOUR
//   - Reset values: core_rst=1, key_out=0, epoch_idx=0, busy=0, ready=0, err=0.
//   - Internal state: valid mask, phase counter 0..NUM_KEYS*EPOCH_LEN-1, RST_CYC counter.
//   - Table writes: cfg_we accepted only in EMPTY; sets valid[cfg_idx].
//     cfg_idx >= NUM_KEYS -> write dropped, err=1.
//   - FSM EMPTY: key_out=0, core_rst=1. cfg_commit with mask all-ones -> READY;
//     any bit missing -> stays EMPTY, err=1.
//   - FSM READY: ready=1, core_rst=1, key_out=0. start -> RSTC.
//   - FSM RSTC: core_rst=1 for exactly RST_CYC cycles; key_out=key[0] from the first RSTC cycle. Then -> RUN with phase=0.
//   - FSM RUN: core_rst=0, key_out=key[phase/EPOCH_LEN], epoch_idx=phase/EPOCH_LEN.
//     Phase increments every cycle and wraps NUM_KEYS*EPOCH_LEN-1 -> 0 (key[NUM_KEYS-1] -> key[0]).
//   - key_out updates on the rising edge, so it is stable at the core's falling-edge sample.
//   - Core cycle c after release always sees key[(c/EPOCH_LEN)%NUM_KEYS].
//   - abort in RSTC/RUN -> READY next cycle: core_rst=1, key_out=0, phase=0.
//   - abort has priority over start in the same cycle.
//   - start while not READY -> ignored, err=1. start while RUN -> ignored, err=1.
//   - cfg_we or cfg_commit outside EMPTY -> ignored, err=1. The table is immutable once committed.
//   - rst at any time -> all reset values, table valid mask cleared.
// CONFIGURATION
//   KEYSEQ_ZEROIZE_EN defined:
//     - abort or any err event clears all key slots to 0 and the valid mask, and goes to EMPTY.
//     - A reload is required before the next start.
//   KEYSEQ_ZEROIZE_EN undefined:
//     - abort goes to READY and keys are retained.
//     - err events only set err.
// STRUCTURE
//   - cutelock_pkg: seq_state_e {EMPTY, READY, RSTC, RUN}, localparam PERIOD = NUM_KEYS*EPOCH_LEN, phase/index width helpers.
//   - Sub-module cutelock_key_table: NUM_KEYS x KEY_W register file.
//     Ports: one write port, one async read port, valid mask, and a zeroize input.
//   - The FSM and phase counter live in the top module.
// TESTING
//   1. Load slots 0..5 = 18'h1CD53, 18'h24406, 18'h345A2, 18'h12051, 18'h00855, 18'h25953; commit; start.
//      -> core_rst high 2 cycles, then key_out = 18'h1CD53 for 6 cycles, 18'h24406 for 6 cycles, ...
//      -> after 36 cycles key_out returns to 18'h1CD53; epoch_idx sequence 0..5,0.
//   2. Load slots 0..4 only, commit -> stays EMPTY, ready=0, err=1; start -> core_rst stays 1, key_out=0.
//   3. Full load/commit, start, abort at RUN phase 17 -> next cycle READY, core_rst=1, key_out=0.
//      Then start -> sequence restarts at key[0].
//   4. Start and abort asserted in the same cycle in READY -> remains READY, core_rst=1, err=0.
//   5. cfg_we during RUN with cfg_key=18'h3FFFF -> err=1, table unchanged.
//      Keys continue per the loaded schedule.
//      With KEYSEQ_ZEROIZE_EN: -> EMPTY, key_out=0, core_rst=1.
//   6. Assert rst mid-RUN (phase 9) asynchronously -> immediately core_rst=1, key_out=0, busy=0.
//      After release, start is rejected (err=1) until the table is reloaded.

Source files
------------

// File: rtl/cutelock_pkg.sv
// ---------------------------------------------------------------------------
// cutelock_pkg
//   Shared types and sizing helpers for the Cute-Lock key sequencer.
//   - seq_state_e : sequencer FSM states (EMPTY, READY, RSTC, RUN)
//   - *_DEF       : default schedule geometry used by the top-level parameters
//   - PERIOD      : core cycles per full key schedule with the default geometry
//   - cnt_w()     : counter/index width for a range of n values (never below 1)
// ---------------------------------------------------------------------------
package cutelock_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        READY = 2'd1,
        RSTC  = 2'd2,
        RUN   = 2'd3
    } seq_state_e;

    localparam int KEY_W_DEF     = 18;
    localparam int NUM_KEYS_DEF  = 6;
    localparam int EPOCH_LEN_DEF = 6;
    localparam int RST_CYC_DEF   = 2;
    localparam int PERIOD        = NUM_KEYS_DEF * EPOCH_LEN_DEF;

    // Width needed to count 0..n-1; a single-value range still gets one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cutelock_key_table.sv
// ---------------------------------------------------------------------------
// cutelock_key_table
//   NUM_KEYS x KEY_W key register file with a per-slot valid mask.
//   Ports:
//     clk_i       clock (rising edge)
//     rst_i       asynchronous active-high reset: clears keys and valid mask
//     we_i        write enable (caller guarantees widx_i is in range)
//     widx_i      write slot index
//     wkey_i      write data
//     zeroize_i   clears every key and the valid mask; wins over a write
//     ridx_i      asynchronous read slot index (out-of-range reads return 0)
//     rkey_o      read data
//     valid_o     one bit per slot, set once that slot has been written
// ---------------------------------------------------------------------------
module cutelock_key_table
    import cutelock_pkg::*;
#(
    parameter  int KEY_W    = KEY_W_DEF,
    parameter  int NUM_KEYS = NUM_KEYS_DEF,
    localparam int IDX_W    = cnt_w(NUM_KEYS)
)(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    widx_i,
    input  logic [KEY_W-1:0]    wkey_i,
    input  logic                zeroize_i,
    input  logic [IDX_W-1:0]    ridx_i,
    output logic [KEY_W-1:0]    rkey_o,
    output logic [NUM_KEYS-1:0] valid_o
);

    logic [KEY_W-1:0]    key_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] valid_q;
    logic [NUM_KEYS-1:0] wr_hit;
    logic [NUM_KEYS-1:0] rd_hit;

    // One-hot slot decode for the write and read ports.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_decode
            assign wr_hit[gi] = we_i && (widx_i == IDX_W'(gi));
            assign rd_hit[gi] = (ridx_i == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (zeroize_i) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (wr_hit[i]) begin
                    key_q[i]   <= wkey_i;
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rkey_o = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (rd_hit[i]) begin
                rkey_o = key_q[i];
            end
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/cutelock_key_sequencer.sv
// ---------------------------------------------------------------------------
// cutelock_key_sequencer
//   Drives the time-varying unlock key schedule into a Cute-Lock locked FSM
//   core. Keys are loaded over a config port and sealed by a commit; a start
//   pulse holds the core in reset for RST_CYC cycles, then releases it while
//   presenting key[(c / EPOCH_LEN) % NUM_KEYS] at core cycle c after release.
//   All outputs are registered on the rising edge so they are stable at the
//   core's falling-edge sample.
//
//   Build option: define KEYSEQ_ZEROIZE_EN to wipe the key table and return
//   to EMPTY on abort (while running) or on any protocol error. Without it,
//   abort returns to READY with keys kept and errors only set err_o.
//
//   Ports:
//     clk_i         clock (rising edge)
//     rst_i         asynchronous active-high reset
//     cfg_we_i      write cfg_key_i into slot cfg_idx_i (EMPTY only)
//     cfg_idx_i     key slot index
//     cfg_key_i     key data
//     cfg_commit_i  seal the table (every slot must have been written)
//     start_i       pulse: reset the core and begin the keyed run
//     abort_i       pulse: stop the run and put the core back in reset
//     core_rst_o    reset to the locked core
//     key_o         key to the core keyinput bus
//     epoch_idx_o   epoch currently driven
//     busy_o        sequencer is in RSTC or RUN
//     ready_o       table committed and idle
//     err_o         sticky protocol error, cleared only by rst_i
// ---------------------------------------------------------------------------
module cutelock_key_sequencer
    import cutelock_pkg::*;
#(
    parameter  int KEY_W     = KEY_W_DEF,
    parameter  int NUM_KEYS  = NUM_KEYS_DEF,
    parameter  int EPOCH_LEN = EPOCH_LEN_DEF,
    parameter  int RST_CYC   = RST_CYC_DEF,
    localparam int IDX_W     = cnt_w(NUM_KEYS)
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_idx_i,
    input  logic [KEY_W-1:0] cfg_key_i,
    input  logic             cfg_commit_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             core_rst_o,
    output logic [KEY_W-1:0] key_o,
    output logic [IDX_W-1:0] epoch_idx_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic             err_o
);

    localparam int SEQ_PERIOD = NUM_KEYS * EPOCH_LEN;
    localparam int PH_W       = cnt_w(SEQ_PERIOD);
    localparam int EC_W       = cnt_w(EPOCH_LEN);
    localparam int RC_W       = cnt_w(RST_CYC);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SEQ_PERIOD - 1);
    localparam logic [EC_W-1:0]  EC_LAST  = EC_W'(EPOCH_LEN - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);
    // One extra bit so NUM_KEYS itself is representable for the range check.
    localparam logic [IDX_W:0]   NK       = (IDX_W + 1)'(NUM_KEYS);

    seq_state_e       state_q;
    logic [PH_W-1:0]  phase_q;
    logic [EC_W-1:0]  ecnt_q;
    logic [RC_W-1:0]  rcnt_q;
    logic             core_rst_q;
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] epoch_q;
    logic             busy_q;
    logic             ready_q;
    logic             err_q;

    logic [PH_W-1:0]  phase_d;
    logic [EC_W-1:0]  ecnt_d;
    logic [IDX_W-1:0] epoch_d;
    logic [IDX_W-1:0] rd_idx;
    logic [KEY_W-1:0] rd_key;
    logic [NUM_KEYS-1:0] valid_mask;

    logic in_empty;
    logic active;
    logic abort_hit;
    logic idx_ok;
    logic mask_full;
    logic cfg_bad;
    logic idx_bad;
    logic commit_bad;
    logic commit_ok;
    logic start_bad;
    logic err_evt;
    logic tbl_we;
    logic zeroize;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    assign in_empty   = (state_q == EMPTY);
    assign active     = (state_q == RSTC) || (state_q == RUN);
    assign abort_hit  = abort_i && active;
    assign idx_ok     = ({1'b0, cfg_idx_i} < NK);
    assign mask_full  = &valid_mask;

    assign cfg_bad    = (cfg_we_i || cfg_commit_i) && !in_empty;
    assign idx_bad    = cfg_we_i && in_empty && !idx_ok;
    assign commit_bad = cfg_commit_i && in_empty && !mask_full;
    assign commit_ok  = cfg_commit_i && in_empty && mask_full;
    // abort outranks start, so a start paired with abort is silently dropped.
    assign start_bad  = start_i && !abort_i && (state_q != READY);
    assign err_evt    = cfg_bad || idx_bad || commit_bad || start_bad;

    assign tbl_we     = cfg_we_i && in_empty && idx_ok;

`ifdef KEYSEQ_ZEROIZE_EN
    assign zeroize    = abort_hit || err_evt;
`else
    assign zeroize    = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next position in the schedule. The table is read with the index of the
    // epoch that will be current after this edge, so key_o lands registered
    // in the same cycle as epoch_idx_o.
    // -----------------------------------------------------------------------
    assign phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    assign ecnt_d  = (ecnt_q == EC_LAST)  ? '0 : ecnt_q + 1'b1;

    always_comb begin
        epoch_d = epoch_q;
        if (ecnt_q == EC_LAST) begin
            epoch_d = (epoch_q == IDX_LAST) ? '0 : epoch_q + 1'b1;
        end
    end

    // Outside RUN the only key ever loaded into key_q is key[0].
    assign rd_idx = (state_q == RUN) ? epoch_d : '0;

    cutelock_key_table #(
        .KEY_W    (KEY_W),
        .NUM_KEYS (NUM_KEYS)
    ) u_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (tbl_we),
        .widx_i    (cfg_idx_i),
        .wkey_i    (cfg_key_i),
        .zeroize_i (zeroize),
        .ridx_i    (rd_idx),
        .rkey_o    (rd_key),
        .valid_o   (valid_mask)
    );

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            phase_q    <= '0;
            ecnt_q     <= '0;
            rcnt_q     <= '0;
            core_rst_q <= 1'b1;
            key_q      <= '0;
            epoch_q    <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (err_evt) begin
                err_q <= 1'b1;
            end

            case (state_q)
                EMPTY: begin
                    if (commit_ok) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end

                READY: begin
                    if (!abort_i && start_i) begin
                        state_q <= RSTC;
                        rcnt_q  <= '0;
                        key_q   <= rd_key;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end

                RSTC: begin
                    if (abort_i) begin
                        state_q    <= READY;
                        core_rst_q <= 1'b1;
                        key_q      <= '0;
                        epoch_q    <= '0;
                        phase_q    <= '0;
                        ecnt_q     <= '0;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                    end else if (rcnt_q == RC_LAST) begin
                        state_q    <= RUN;
                        core_rst_q <= 1'b0;
                        key_q      <= rd_key;
                        epoch_q    <= '0;
                        phase_q    <= '0;
                        ecnt_q     <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end

                RUN: begin
                    if (abort_i) begin
                        state_q    <= READY;
                        core_rst_q <= 1'b1;
                        key_q      <= '0;
                        epoch_q    <= '0;
                        phase_q    <= '0;
                        ecnt_q     <= '0;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                    end else begin
                        phase_q <= phase_d;
                        ecnt_q  <= ecnt_d;
                        epoch_q <= epoch_d;
                        key_q   <= rd_key;
                    end
                end

                default: begin
                    state_q <= EMPTY;
                end
            endcase

            // Zeroize overrides whatever the FSM chose above.
            if (zeroize) begin
                state_q    <= EMPTY;
                core_rst_q <= 1'b1;
                key_q      <= '0;
                epoch_q    <= '0;
                phase_q    <= '0;
                ecnt_q     <= '0;
                rcnt_q     <= '0;
                busy_q     <= 1'b0;
                ready_q    <= 1'b0;
            end
        end
    end

    assign core_rst_o  = core_rst_q;
    assign key_o       = key_q;
    assign epoch_idx_o = epoch_q;
    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_cutelock_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cutelock_key_sequencer
//   Scoreboard bench for cutelock_key_sequencer. The driver issues one input
//   vector per clock, steps a behavioural model and queues the expected
//   outputs; a monitor pops and compares on every falling edge.
//   Honours KEYSEQ_ZEROIZE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cutelock_key_sequencer;

    localparam int KEY_W     = 18;
    localparam int NUM_KEYS  = 6;
    localparam int EPOCH_LEN = 6;
    localparam int RST_CYC   = 2;
    localparam int IDX_W     = 3;

    typedef struct packed {
        logic             core_rst;
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] epoch;
        logic             busy;
        logic             ready;
        logic             err;
    } out_t;

    typedef enum int {M_EMPTY, M_READY, M_RUN} mode_e;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [KEY_W-1:0] cfg_key = '0;
    logic             cfg_commit = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;

    logic             core_rst;
    logic [KEY_W-1:0] key_out;
    logic [IDX_W-1:0] epoch_idx;
    logic             busy;
    logic             ready;
    logic             err;

    int tests_run = 0;
    int tests_failed = 0;

    out_t exp_q[$];

    // Reference model state
    mode_e            m_mode = M_EMPTY;
    logic [KEY_W-1:0] m_key [NUM_KEYS];
    bit               m_valid [NUM_KEYS];
    bit               m_err = 1'b0;
    int               m_t = 0;   // cycles since the start was accepted

    logic [KEY_W-1:0] sched [NUM_KEYS] = '{18'h1CD53, 18'h24406, 18'h345A2,
                                           18'h12051, 18'h00855, 18'h25953};

    always #5 clk = ~clk;

    cutelock_key_sequencer #(
        .KEY_W     (KEY_W),
        .NUM_KEYS  (NUM_KEYS),
        .EPOCH_LEN (EPOCH_LEN),
        .RST_CYC   (RST_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_key_i    (cfg_key),
        .cfg_commit_i (cfg_commit),
        .start_i      (start),
        .abort_i      (abort),
        .core_rst_o   (core_rst),
        .key_o        (key_out),
        .epoch_idx_o  (epoch_idx),
        .busy_o       (busy),
        .ready_o      (ready),
        .err_o        (err)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic void model_clear();
        for (int i = 0; i < NUM_KEYS; i++) begin
            m_key[i]   = '0;
            m_valid[i] = 1'b0;
        end
        m_mode = M_EMPTY;
        m_t    = 0;
    endfunction

    function automatic void model_step();
        bit errev = 1'b0;
        bit full  = 1'b1;
        int idx;
        if (rst) begin
            model_clear();
            m_err = 1'b0;
            return;
        end
        for (int i = 0; i < NUM_KEYS; i++) if (!m_valid[i]) full = 1'b0;
        idx = int'(cfg_idx);
        case (m_mode)
            M_EMPTY: begin
                if (cfg_we) begin
                    if (idx < NUM_KEYS) begin
                        m_key[idx]   = cfg_key;
                        m_valid[idx] = 1'b1;
                    end else begin
                        errev = 1'b1;
                    end
                end
                if (cfg_commit) begin
                    if (full) m_mode = M_READY;
                    else      errev  = 1'b1;
                end
                if (start && !abort) errev = 1'b1;
            end
            M_READY: begin
                if (cfg_we || cfg_commit) errev = 1'b1;
                if (start && !abort) begin
                    m_mode = M_RUN;
                    m_t    = 0;
                end
            end
            default: begin
                if (cfg_we || cfg_commit) errev = 1'b1;
                if (abort) begin
`ifdef KEYSEQ_ZEROIZE_EN
                    model_clear();
`else
                    m_mode = M_READY;
`endif
                end else begin
                    if (start) errev = 1'b1;
                    m_t++;
                end
            end
        endcase
        if (errev) begin
            m_err = 1'b1;
`ifdef KEYSEQ_ZEROIZE_EN
            model_clear();
`endif
        end
    endfunction

    function automatic out_t model_out();
        out_t o;
        int   c;
        int   e;
        o = '0;
        o.err = m_err;
        case (m_mode)
            M_EMPTY: o.core_rst = 1'b1;
            M_READY: begin
                o.core_rst = 1'b1;
                o.ready    = 1'b1;
            end
            default: begin
                o.busy = 1'b1;
                if (m_t < RST_CYC) begin
                    o.core_rst = 1'b1;
                    o.key      = m_key[0];
                end else begin
                    c       = m_t - RST_CYC;
                    e       = (c / EPOCH_LEN) % NUM_KEYS;
                    o.key   = m_key[e];
                    o.epoch = IDX_W'(e);
                end
            end
        endcase
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        exp_q.push_back(model_out());
        #1;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_key(input int idx, input logic [KEY_W-1:0] k);
        $display("[TB] cfg_we idx=%0d key=%05h", idx, k);
        cfg_we  = 1'b1;
        cfg_idx = IDX_W'(idx);
        cfg_key = k;
        tick();
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) write_key(i, sched[i]);
    endtask

    task automatic do_commit();
        $display("[TB] cfg_commit");
        cfg_commit = 1'b1;
        tick();
    endtask

    task automatic do_start();
        $display("[TB] start");
        start = 1'b1;
        tick();
    endtask

    task automatic do_abort();
        $display("[TB] abort");
        abort = 1'b1;
        tick();
    endtask

    // Asserts rst between clock edges and checks the outputs react at once.
    task automatic async_reset();
        out_t act;
        @(negedge clk);
        #1;
        $display("[TB] async rst");
        rst = 1'b1;
        #1;
        act = {core_rst, key_out, epoch_idx, busy, ready, err};
        tests_run++;
        if (act !== out_t'({1'b1, {KEY_W{1'b0}}, {IDX_W{1'b0}}, 3'b000})) begin
            tests_failed++;
            $display("FAIL async_rst: got rst=%0b key=%05h ep=%0d busy=%0b rdy=%0b err=%0b, want rst=1 key=00000 ep=0 busy=0 rdy=0 err=0",
                     act.core_rst, act.key, act.epoch, act.busy, act.ready, act.err);
        end
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {core_rst, key_out, epoch_idx, busy, ready, err};
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL outputs @%0t: got rst=%0b key=%05h ep=%0d busy=%0b rdy=%0b err=%0b, want rst=%0b key=%05h ep=%0d busy=%0b rdy=%0b err=%0b",
                             $time, a.core_rst, a.key, a.epoch, a.busy, a.ready, a.err,
                             e.core_rst, e.key, e.epoch, e.busy, e.ready, e.err);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int r;
        model_clear();
        // Reset state
        run(2);
        rst = 1'b0;
        run(1);

        // Full schedule: two RSTC cycles, then 6 keys x 6 cycles and wrap
        load(NUM_KEYS);
        do_commit();
        do_start();
        run(RST_CYC + 40);

        // Abort at RUN phase 17, then restart from key[0]
        do_abort();
        run(1);
        do_start();
        run(RST_CYC + 17);
        do_abort();
        run(1);
        do_start();
        run(RST_CYC + 8);
        do_abort();
        run(1);

        // start and abort together while READY
        $display("[TB] start+abort");
        start = 1'b1;
        abort = 1'b1;
        tick();
        run(2);

        // Config write while running
        do_start();
        run(RST_CYC + 5);
        write_key(0, 18'h3FFFF);
        run(12);
        do_abort();
        run(1);

        // Asynchronous reset at RUN phase 9, then start is refused
        async_reset();
        load(NUM_KEYS);
        do_commit();
        do_start();
        run(RST_CYC + 9);
        async_reset();
        run(1);
        do_start();
        run(3);

        // Partial load: commit refused, start keeps the core in reset
        async_reset();
        load(NUM_KEYS - 1);
        do_commit();
        do_start();
        run(3);

        // Out-of-range slot index
        async_reset();
        write_key(7, 18'h15555);
        run(2);

        // Randomised traffic
        async_reset();
        for (int n = 0; n < 1200; n++) begin
            r = $urandom_range(0, 199);
            if (r < 100) begin
                tick();
            end else if (r < 150) begin
                write_key($urandom_range(0, 7), KEY_W'($urandom));
            end else if (r < 162) begin
                do_commit();
            end else if (r < 176) begin
                do_start();
            end else if (r < 188) begin
                do_abort();
            end else if (r < 193) begin
                $display("[TB] start+abort");
                start = 1'b1;
                abort = 1'b1;
                tick();
            end else if (r < 196) begin
                async_reset();
            end else begin
                load(NUM_KEYS);
                do_commit();
            end
        end

        // Drain the scoreboard
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
